// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared constants and preamble lookup for the S/PDIF transmitter
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam int FRAMES_PER_BLOCK  = 192;
    localparam int HALFCELLS_PER_SUB = 64;

    localparam int SLOT_DATA0 = 4;
    localparam int SLOT_V     = 28;
    localparam int SLOT_U     = 29;
    localparam int SLOT_C     = 30;
    localparam int SLOT_P     = 31;

    typedef enum logic [1:0] {
        PRE_SEL_B,
        PRE_SEL_M,
        PRE_SEL_W
    } pre_sel_t;

    function automatic logic [7:0] preamble_bits(input pre_sel_t sel);
        logic [7:0] bits;
        case (sel)
            PRE_SEL_B: bits = PRE_B;
            PRE_SEL_M: bits = PRE_M;
            default:   bits = PRE_W;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// rtl/spdif_bmc_enc.sv - biphase-mark line encoder with preamble inversion
module spdif_bmc_enc (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    input  logic pre_phase,
    input  logic pre_bit,
    input  logic data_bit,
    input  logic slot_phase,
    output logic bmc_out
);

    logic inv;
    logic data_next;

    always_comb begin
        data_next = slot_phase ? ~bmc_out : (bmc_out ^ data_bit);
    end

    // inv tracks the last data-driven level, i.e. the line level seen at the next subframe boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bmc_out <= 1'b0;
            inv     <= 1'b0;
        end else if (strobe) begin
            if (pre_phase) begin
                bmc_out <= pre_bit ^ inv;
            end else begin
                bmc_out <= data_next;
                inv     <= data_next;
            end
        end
    end

endmodule

// File: rtl/spdif_tx.sv
// rtl/spdif_tx.sv - S/PDIF subframe timebase, sample latch, shift register and parity
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int DATA_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] left_sample,
    input  logic [DATA_W-1:0] right_sample,
    output logic              spdif_left_accepted,
    output logic              spdif_right_accepted,
    output logic              spdif_out
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [5:0] HC_LAST    = 6'(HALFCELLS_PER_SUB - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);

    logic [7:0]        div_cnt;
    logic [5:0]        hc;
    logic              sub;
    logic [7:0]        frame;
    logic [DATA_W-1:0] shreg;
    logic              parity;

    logic       strobe;
    logic       div_wrap;
    logic       latch;
    logic [4:0] slot;
    logic       pre_phase;
    logic       slot_phase;
    logic       in_data;
    logic       pre_bit;
    logic       data_bit;
    pre_sel_t   pre_sel;
    logic [7:0] pre_pat;

    always_comb begin
        strobe     = (div_cnt == 8'd0);
        div_wrap   = (div_cnt == DIV_LAST);
        latch      = strobe && (hc == 6'd0);
        slot       = hc[5:1];
        pre_phase  = (slot < 5'(SLOT_DATA0));
        slot_phase = ~hc[0];
        in_data    = (slot >= 5'(SLOT_DATA0)) && (slot < 5'(SLOT_V));

        if (sub)
            pre_sel = PRE_SEL_W;
        else if (frame == 8'd0)
            pre_sel = PRE_SEL_B;
        else
            pre_sel = PRE_SEL_M;
        pre_pat = preamble_bits(pre_sel);
        pre_bit = pre_pat[3'd7 - hc[2:0]];

        // V, U and C are constant zero, so only sample bits and P reach the line
        if (in_data)
            data_bit = shreg[0];
        else if (slot == 5'(SLOT_P))
            data_bit = parity;
        else
            data_bit = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt              <= 8'd0;
            hc                   <= 6'd0;
            sub                  <= 1'b0;
            frame                <= 8'd0;
            shreg                <= '0;
            parity               <= 1'b0;
            spdif_left_accepted  <= 1'b0;
            spdif_right_accepted <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            if (div_wrap) begin
                hc <= hc + 6'd1;
                if (hc == HC_LAST) begin
                    sub <= ~sub;
                    if (sub)
                        frame <= (frame == FRAME_LAST) ? 8'd0 : frame + 8'd1;
                end
            end

            spdif_left_accepted  <= latch && !sub;
            spdif_right_accepted <= latch && sub;

            // bits leave at mid-slot, the same edge that emits them onto the line
            if (latch) begin
                shreg  <= sub ? right_sample : left_sample;
                parity <= 1'b0;
            end else if (strobe && !slot_phase && in_data) begin
                shreg  <= shreg >> 1;
                parity <= parity ^ shreg[0];
            end
        end
    end

    spdif_bmc_enc u_bmc (
        .clk        (clk),
        .reset_n    (reset_n),
        .strobe     (strobe),
        .pre_phase  (pre_phase),
        .pre_bit    (pre_bit),
        .data_bit   (data_bit),
        .slot_phase (slot_phase),
        .bmc_out    (spdif_out)
    );

endmodule

// File: doc/spdif_tx.md
# spdif_tx

Serialises one stereo PCM sample pair per S/PDIF frame into a biphase-mark-coded IEC 60958 line signal. It sits directly upstream of the control block.
- It latches the left and right samples at the start of their subframes.
- It reports each latch with a one-cycle `spdif_left_accepted` / `spdif_right_accepted` pulse, which the control block turns into requests for the next samples.

## Interface
- `CLK_DIV`, default 8: clk cycles per biphase half-cell; legal values 2..255.
- `DATA_W`, default 24: sample width; fixed at 24.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `left_sample`  in  24  signed PCM left sample; sampled on the latch edge.
- `right_sample`  in  24  signed PCM right sample; sampled on the latch edge.
- `spdif_left_accepted`  out  1  one-cycle pulse: left sample latched.
- `spdif_right_accepted`  out  1  one-cycle pulse: right sample latched.
- `spdif_out`  out  1  BMC-encoded S/PDIF line level.

## Operation
- Timebase:
  - `div_cnt` counts 0..CLK_DIV-1.
  - The half-cell index `hc` counts 0..63 and advances when `div_cnt` wraps.
  - The subframe flag `sub` selects 0 = left, 1 = right and toggles when `hc` wraps.
  - `frame` counts 0..191 and advances after the right subframe.
- Subframe layout, 32 slots of 2 half-cells each:
  - Slots 0-3 carry the preamble.
  - Slots 4-27 carry the sample, LSB first.
  - Slot 28 is V=0, slot 29 is U=0, slot 30 is C=0.
  - Slot 31 is P, chosen so that slots 4-31 contain an even number of ones.
- Preamble selection:
  - B for a left subframe of frame 0.
  - M for every other left subframe.
  - W for a right subframe.
- Preambles are 8 half-cell patterns, MSB first, referenced to a low previous level:
  - B = 11101000
  - M = 11100010
  - W = 11100100
  - The pattern is inverted when `spdif_out` is high at the subframe boundary.
- Data slots use biphase mark coding:
  - `spdif_out` toggles at the start of every slot.
  - It toggles again at mid-slot when the bit is 1.
- Latch:
  - The latch edge is the edge on which `div_cnt`=0, `hc`=0 and `sub`=0.
  - On that edge `left_sample` loads into the 24-bit shift register, the parity accumulator clears, and `spdif_left_accepted` goes high for exactly the following cycle.
  - The right subframe behaves identically with `sub`=1, `right_sample` and `spdif_right_accepted`.
  - Input samples are not otherwise observed and carry no handshake beyond the pulse.
- Parity accumulates over slots 4-30 as each bit is shifted out.
- Reset:
  - On `reset_n` low, all counters, the shift register, parity, `spdif_out` and both accepted pulses clear to 0, immediately and asynchronously.
  - A subframe aborted mid-stream is discarded.
  - After release, the first rising edge is a latch edge for a left subframe of frame 0, so the first preamble is B.

## Timing
- Subframe length is 64·CLK_DIV cycles; frame length is 128·CLK_DIV cycles.
- Accepted pulses alternate left/right, spaced 64·CLK_DIV cycles apart, each exactly 1 cycle wide.
- `spdif_out` is registered:
  - Half-cell k of a subframe is driven from the edge where `hc`=k and `div_cnt`=0.
  - It is held for CLK_DIV cycles.
  - The first preamble half-cell appears in the same cycle as the accepted pulse.
- The B preamble repeats every 192 frames, i.e. 192·128·CLK_DIV cycles.
- The line level at the end of each subframe is deterministic because parity is even. The inversion rule must still be applied from the actual `spdif_out` level, not assumed.

## Structure
- Shared package `spdif_pkg` holds:
  - Preamble constants `PRE_B`, `PRE_M`, `PRE_W` (8 bits each).
  - `FRAMES_PER_BLOCK`=192 and `HALFCELLS_PER_SUB`=64.
  - Slot indices `SLOT_DATA0`=4, `SLOT_V`=28, `SLOT_U`=29, `SLOT_C`=30, `SLOT_P`=31.
- Sub-module `spdif_bmc_enc`:
  - Takes a per-half-cell strobe, a preamble-phase flag, a preamble half-cell bit, a data bit and a slot-phase flag.
  - Owns the `spdif_out` register and the toggle/inversion logic.
- The top level holds the timebase, frame counter, shift register, parity and latch logic.

## Test plan
- Reset check: hold `reset_n` low for 5 cycles.
  - During reset, all outputs are 0.
  - On the first edge after release, `spdif_left_accepted`=1 for 1 cycle.
  - `spdif_out` half-cells 0-7 read 11101000.
- Pulse spacing with CLK_DIV=8: run for 4 frames.
  - Accepted pulses alternate L,R,L,R… at exactly 512-cycle spacing.
  - No double pulses occur.
- Payload decode: `left_sample`=0x000001, `right_sample`=0xFFFFFF; decode BMC in the bench.
  - Left slots 4..27 decode to 1 followed by 23 zeros, with P=1.
  - Right slots 4..27 decode to all ones, with P=0.
  - V, U and C decode to 0.
- Block wrap: run for 193 frames.
  - Frame 0 and frame 192 left subframes carry B.
  - Frames 1-191 left subframes carry M, and every right subframe carries W.
- Mid-subframe reset: assert `reset_n` low at `hc`=30 of a right subframe.
  - All outputs go to 0 within the same cycle.
  - After release, the stream restarts with a left latch pulse and preamble B.
- Minimum divider, CLK_DIV=2: run 2 frames with random samples.
  - The bench BMC decoder recovers all 4 samples bit-exact.
  - Parity checks pass and no preamble/data boundary glitch appears.
